sdm_req_ctl: RTL

SDM_REQ_CTL -- requirements
Module: sdm_req_ctl

---
 rtl/sdm_req_ctl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sdm_req_ctl.sv
// ---------------------------------------------------------------------------
// sdm_req_ctl
//
// Input-side request controller for one client of a spatial-division
// multiplexed router. It raises a four-phase request toward the
// asynchronous match arbiter when a head flit arrives. It captures the
// granted resource column into a registered one-hot grant. It holds that
// connection until the tail flit passes. Then it waits for the arbiter to
// drop its acknowledge before it accepts a new head.
//
// Parameters
//   M   : number of resources (virtual circuits) on the downstream port
//   TW  : width of the request timeout counter
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   hd_vld    in   head flit present, requesting a connection
//   hd_rdy    out  one-cycle pulse when the head is accepted (grant made)
//   tl_vld    in   tail flit of the current packet transferred this cycle
//   c         out  four-phase request to the match arbiter
//   ca        in   asynchronous acknowledge from the match arbiter
//   cfg_col   in   this client's arbiter configuration column (M bits)
//   grant_vld out  a connection is held and grant is valid
//   grant     out  registered one-hot resource selection (M bits)
//   to_err    out  sticky request-timeout flag
//
// Optional feature
//   SDM_REQ_TIMEOUT_EN : when defined, a saturating TW-bit counter runs
//   while a request is outstanding. to_err sets once the counter
//   saturates. When undefined, no counter exists and to_err is 0.
// ---------------------------------------------------------------------------
module sdm_req_ctl #(
    parameter int M  = 2,
    parameter int TW = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hd_vld,
    output logic         hd_rdy,
    input  logic         tl_vld,
    output logic         c,
    input  logic         ca,
    input  logic [M-1:0] cfg_col,
    output logic         grant_vld,
    output logic [M-1:0] grant,
    output logic         to_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2,
        REL  = 2'd3
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic         ca_m;
    logic         ca_s;
    logic [M-1:0] grant_d;
    logic         hd_rdy_d;
    logic         c_d;
    logic         grant_vld_d;

    // The acknowledge arrives from self-timed logic. It is brought into
    // the clock domain through two flops before the FSM looks at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ca_m <= 1'b0;
            ca_s <= 1'b0;
        end else begin
            ca_m <= ca;
            ca_s <= ca_m;
        end
    end

    // The handshake follows a return-to-zero sequence. A new request is
    // raised only once the previous acknowledge has been seen low. A
    // raised request is never withdrawn before it is acknowledged. An
    // acknowledge with an empty column means the arbiter has not settled
    // yet, so the FSM stays in REQ and samples again.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant;
        hd_rdy_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (hd_vld && !ca_s) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ca_s && (|cfg_col)) begin
                    state_d  = BUSY;
                    grant_d  = cfg_col;
                    hd_rdy_d = 1'b1;
                end
            end
            BUSY: begin
                if (tl_vld) begin
                    state_d = REL;
                    grant_d = '0;
                end
            end
            REL: begin
                grant_d = '0;
                if (!ca_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        c_d         = (state_d == REQ) || (state_d == BUSY);
        grant_vld_d = (state_d == BUSY);
    end

    // All outputs seen by the asynchronous arbiter and the crossbar come
    // straight from flops. Their next values are decoded from the next
    // state, so they change in step with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            c         <= 1'b0;
            grant_vld <= 1'b0;
            grant     <= '0;
            hd_rdy    <= 1'b0;
        end else begin
            state_q   <= state_d;
            c         <= c_d;
            grant_vld <= grant_vld_d;
            grant     <= grant_d;
            hd_rdy    <= hd_rdy_d;
        end
    end

`ifdef SDM_REQ_TIMEOUT_EN
    localparam logic [TW-1:0] CNT_MAX = {TW{1'b1}};

    logic [TW-1:0] to_cnt;
    logic          to_err_q;

    // The counter restarts each time a request is raised and counts cycles
    // spent waiting in REQ. The error flag sets on the cycle the counter
    // reaches its maximum. Only reset clears the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt   <= '0;
            to_err_q <= 1'b0;
        end else begin
            if ((state_q != REQ) && (state_d == REQ)) begin
                to_cnt <= '0;
            end else if ((state_q == REQ) && (to_cnt != CNT_MAX)) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if ((state_q == REQ) && (to_cnt == CNT_MAX - 1'b1)) begin
                to_err_q <= 1'b1;
            end
        end
    end

    assign to_err = to_err_q;
`else
    logic [TW-1:0] unused_tw_width;

    assign unused_tw_width = '0;
    assign to_err          = 1'b0;
`endif

endmodule
